// File: rtl/pht_pkg.sv
// Shared helpers for the pattern history table: counter state constants,
// saturating counter arithmetic and the index hash.
package pht_pkg;

  localparam int unsigned DEFAULT_CTR_WIDTH = 2;
  localparam logic [31:0] CTR_STRONG_NT     = 32'd0;

  function automatic logic [31:0] ctr_weak_taken(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] ctr_strong_taken(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] ctr, input int unsigned width);
    logic [31:0] maxv;
    maxv = ctr_strong_taken(width);
    return (ctr >= maxv) ? maxv : ctr + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] ctr, input int unsigned width);
    return (ctr == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr - 32'd1;
  endfunction

  function automatic logic [31:0] pht_hash(input logic [31:0] ghr, input logic [31:0] pc_bits,
                                           input logic mode);
    return mode ? (ghr ^ pc_bits) : ghr;
  endfunction

endpackage

// File: rtl/global_history_reg.sv
// Global history register: speculative shift-in on lookup, restore from a
// carried snapshot on mispredict (restore wins over a same-cycle shift).
module global_history_reg #(
  parameter int HIST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_shift_en,
  input  logic                  i_shift_bit,
  input  logic                  i_restore_en,
  input  logic [HIST_WIDTH-1:0] i_restore_ghr,
  input  logic                  i_restore_bit,
  output logic [HIST_WIDTH-1:0] o_ghr
);

  logic [HIST_WIDTH-1:0] r_ghr;
  logic [HIST_WIDTH-1:0] w_spec_next;
  logic [HIST_WIDTH-1:0] w_repair_next;

  assign w_spec_next   = (r_ghr << 1) | HIST_WIDTH'(i_shift_bit);
  assign w_repair_next = (i_restore_ghr << 1) | HIST_WIDTH'(i_restore_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (i_restore_en) begin
      r_ghr <= w_repair_next;
    end else if (i_shift_en) begin
      r_ghr <= w_spec_next;
    end
  end

  assign o_ghr = r_ghr;

endmodule

// File: rtl/gshare_pattern_history_table.sv
// Parametrised pattern history table with owned GHR, optional gshare hashing,
// saturating n-bit counters and saturating performance counters.
module gshare_pattern_history_table
  import pht_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int HIST_WIDTH = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int INDEX_MODE = 1,
  parameter int PC_SHIFT   = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_taken,
  output logic                  pred_valid,
  output logic [HIST_WIDTH-1:0] pred_index,
  output logic [HIST_WIDTH-1:0] pred_ghr,
  input  logic                  upd_valid,
  input  logic [HIST_WIDTH-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [HIST_WIDTH-1:0] upd_ghr,
  output logic [HIST_WIDTH-1:0] ghr_out,
  output logic [STAT_WIDTH-1:0] perf_lookups,
  output logic [STAT_WIDTH-1:0] perf_mispred
);

  localparam int DEPTH = 1 << HIST_WIDTH;
  localparam logic [CTR_WIDTH-1:0]  WEAK_T   = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0]  WEAK_NT  = WEAK_T - CTR_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [CTR_WIDTH-1:0]  r_ctr [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [STAT_WIDTH-1:0] r_perf_lookups;
  logic [STAT_WIDTH-1:0] r_perf_mispred;

  logic [HIST_WIDTH-1:0] w_ghr;
  logic [HIST_WIDTH-1:0] w_pc_bits;
  logic [HIST_WIDTH-1:0] w_idx;
  logic                  w_pred_valid;
  logic                  w_pred_taken;
  logic                  w_recover;
  logic [CTR_WIDTH-1:0]  w_upd_ctr;

  assign w_pc_bits    = lookup_pc[PC_SHIFT +: HIST_WIDTH];
  assign w_idx        = HIST_WIDTH'(pht_hash(32'(w_ghr), 32'(w_pc_bits), INDEX_MODE != 0));
  assign w_pred_valid = lookup_valid & r_valid[w_idx];
  assign w_pred_taken = w_pred_valid & r_ctr[w_idx][CTR_WIDTH-1];
  assign w_recover    = upd_valid & upd_mispredict;

  assign pred_valid = w_pred_valid;
  assign pred_taken = w_pred_taken;
  assign pred_index = lookup_valid ? w_idx : '0;
  assign pred_ghr   = lookup_valid ? w_ghr : '0;

  global_history_reg #(
    .HIST_WIDTH (HIST_WIDTH)
  ) u_ghr (
    .clk           (clk),
    .reset         (reset),
    .i_shift_en    (lookup_valid),
    .i_shift_bit   (w_pred_taken),
    .i_restore_en  (w_recover),
    .i_restore_ghr (upd_ghr),
    .i_restore_bit (upd_taken),
    .o_ghr         (w_ghr)
  );

  assign ghr_out = w_ghr;

  // A first training lands in the weak state on the side of the outcome.
  always_comb begin
    w_upd_ctr = WEAK_T;
    if (!r_valid[upd_index]) begin
      w_upd_ctr = upd_taken ? WEAK_T : WEAK_NT;
    end else if (upd_taken) begin
      w_upd_ctr = CTR_WIDTH'(sat_inc(32'(r_ctr[upd_index]), CTR_WIDTH));
    end else begin
      w_upd_ctr = CTR_WIDTH'(sat_dec(32'(r_ctr[upd_index]), CTR_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= WEAK_T;
      end
    end else if (upd_valid) begin
      r_valid[upd_index] <= 1'b1;
      r_ctr[upd_index]   <= w_upd_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_lookups <= '0;
      r_perf_mispred <= '0;
    end else begin
      if (lookup_valid && (r_perf_lookups != STAT_MAX)) begin
        r_perf_lookups <= r_perf_lookups + STAT_WIDTH'(1);
      end
      if (w_recover && (r_perf_mispred != STAT_MAX)) begin
        r_perf_mispred <= r_perf_mispred + STAT_WIDTH'(1);
      end
    end
  end

  assign perf_lookups = r_perf_lookups;
  assign perf_mispred = r_perf_mispred;

endmodule

// File: tb/tb_gshare_pattern_history_table.sv
// Directed bench for gshare_pattern_history_table: one gshare instance and one
// history-indexed instance with narrow perf counters to reach saturation.
module tb_gshare_pattern_history_table;

  logic        clk;
  logic        reset;
  logic        lookupValid;
  logic [31:0] lookupPc;
  logic        predTaken;
  logic        predValid;
  logic [3:0]  predIndex;
  logic [3:0]  predGhr;
  logic        updValid;
  logic [3:0]  updIndex;
  logic        updTaken;
  logic        updMispredict;
  logic [3:0]  updGhr;
  logic [3:0]  ghrOut;
  logic [15:0] perfLookups;
  logic [15:0] perfMispred;

  logic        lookupValid0;
  logic [31:0] lookupPc0;
  logic        predTaken0;
  logic        predValid0;
  logic [3:0]  predIndex0;
  logic [3:0]  predGhr0;
  logic        updValid0;
  logic [3:0]  updIndex0;
  logic        updTaken0;
  logic        updMispredict0;
  logic [3:0]  updGhr0;
  logic [3:0]  ghrOut0;
  logic [1:0]  perfLookups0;
  logic [1:0]  perfMispred0;

  int nChecks = 0;
  int nErrors = 0;

  gshare_pattern_history_table #(
    .PC_WIDTH(32), .HIST_WIDTH(4), .CTR_WIDTH(2), .INDEX_MODE(1), .PC_SHIFT(2), .STAT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookupValid), .lookup_pc(lookupPc),
    .pred_taken(predTaken), .pred_valid(predValid), .pred_index(predIndex), .pred_ghr(predGhr),
    .upd_valid(updValid), .upd_index(updIndex), .upd_taken(updTaken),
    .upd_mispredict(updMispredict), .upd_ghr(updGhr),
    .ghr_out(ghrOut), .perf_lookups(perfLookups), .perf_mispred(perfMispred)
  );

  gshare_pattern_history_table #(
    .PC_WIDTH(32), .HIST_WIDTH(4), .CTR_WIDTH(2), .INDEX_MODE(0), .PC_SHIFT(2), .STAT_WIDTH(2)
  ) dutHist (
    .clk(clk), .reset(reset),
    .lookup_valid(lookupValid0), .lookup_pc(lookupPc0),
    .pred_taken(predTaken0), .pred_valid(predValid0), .pred_index(predIndex0), .pred_ghr(predGhr0),
    .upd_valid(updValid0), .upd_index(updIndex0), .upd_taken(updTaken0),
    .upd_mispredict(updMispredict0), .upd_ghr(updGhr0),
    .ghr_out(ghrOut0), .perf_lookups(perfLookups0), .perf_mispred(perfMispred0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so each rising edge sees settled values.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; lookupValid = 1'b0; lookupPc = 32'h0;
    updValid = 1'b0; updIndex = 4'h0; updTaken = 1'b0; updMispredict = 1'b0; updGhr = 4'h0;
    lookupValid0 = 1'b0; lookupPc0 = 32'h0;
    updValid0 = 1'b0; updIndex0 = 4'h0; updTaken0 = 1'b0; updMispredict0 = 1'b0; updGhr0 = 4'h0;

    // Reset held for two edges, then look at the cold table.
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    lookupValid = 1'b1; lookupPc = 32'h40;
    #1;
    checkOutput("rst_pred_valid", 32'(predValid), 32'd0);
    checkOutput("rst_pred_taken", 32'(predTaken), 32'd0);
    checkOutput("rst_ghr", 32'(ghrOut), 32'd0);
    checkOutput("rst_perf_lookups", 32'(perfLookups), 32'd0);
    checkOutput("rst_perf_mispred", 32'(perfMispred), 32'd0);
    applyStimulus();
    #1;
    checkOutput("lookup_count1", 32'(perfLookups), 32'd1);
    checkOutput("ghr_after_nt_lookup", 32'(ghrOut), 32'd0);
    lookupValid = 1'b0; lookupPc = 32'h24;
    #1;
    checkOutput("idle_pred_index", 32'(predIndex), 32'd0);

    // Cold not-taken update to index 5, then one taken update.
    updValid = 1'b1; updIndex = 4'd5; updTaken = 1'b0;
    applyStimulus();
    updValid = 1'b0;
    lookupValid = 1'b1; lookupPc = 32'h14;
    #1;
    checkOutput("cold_valid", 32'(predValid), 32'd1);
    checkOutput("cold_taken", 32'(predTaken), 32'd0);
    checkOutput("cold_index", 32'(predIndex), 32'd5);
    lookupValid = 1'b0;
    updValid = 1'b1; updTaken = 1'b1;
    applyStimulus();
    updValid = 1'b0;
    lookupValid = 1'b1;
    #1;
    checkOutput("warm_taken", 32'(predTaken), 32'd1);
    lookupValid = 1'b0;

    // Saturation on index 3: up to 11, then down to 00 with no wrap.
    updValid = 1'b1; updIndex = 4'd3; updTaken = 1'b1;
    repeat (4) applyStimulus();
    updValid = 1'b0; lookupValid = 1'b1; lookupPc = 32'h0C;
    #1;
    checkOutput("sat_hi_taken", 32'(predTaken), 32'd1);
    lookupValid = 1'b0; updValid = 1'b1; updTaken = 1'b0;
    applyStimulus();
    updValid = 1'b0; lookupValid = 1'b1;
    #1;
    checkOutput("sat_nt1_taken", 32'(predTaken), 32'd1);
    lookupValid = 1'b0; updValid = 1'b1;
    applyStimulus();
    updValid = 1'b0; lookupValid = 1'b1;
    #1;
    checkOutput("sat_nt2_taken", 32'(predTaken), 32'd0);
    checkOutput("sat_nt2_valid", 32'(predValid), 32'd1);
    lookupValid = 1'b0; updValid = 1'b1;
    repeat (3) applyStimulus();
    updValid = 1'b0; lookupValid = 1'b1;
    #1;
    checkOutput("sat_lo_taken", 32'(predTaken), 32'd0);
    lookupValid = 1'b0; updValid = 1'b1; updTaken = 1'b1;
    applyStimulus();
    updValid = 1'b0; lookupValid = 1'b1;
    #1;
    checkOutput("sat_no_wrap", 32'(predTaken), 32'd0);
    lookupValid = 1'b0;

    // Speculative history T,T,N from ghr=0.
    lookupValid = 1'b1; lookupPc = 32'h14;
    #1;
    checkOutput("spec1_taken", 32'(predTaken), 32'd1);
    checkOutput("spec1_pred_ghr", 32'(predGhr), 32'd0);
    applyStimulus();
    #1;
    checkOutput("spec1_ghr", 32'(ghrOut), 32'h1);
    lookupPc = 32'h10;
    #1;
    checkOutput("spec2_taken", 32'(predTaken), 32'd1);
    applyStimulus();
    #1;
    checkOutput("spec2_ghr", 32'(ghrOut), 32'h3);
    lookupPc = 32'h24;
    #1;
    checkOutput("gshare_index", 32'(predIndex), 32'hA);
    checkOutput("gshare_pred_ghr", 32'(predGhr), 32'h3);
    lookupPc = 32'h00;
    #1;
    checkOutput("spec3_taken", 32'(predTaken), 32'd0);
    checkOutput("spec3_index", 32'(predIndex), 32'h3);
    applyStimulus();
    #1;
    checkOutput("spec3_ghr", 32'(ghrOut), 32'h6);

    // Mispredict repair beats a same-cycle lookup shift.
    updValid = 1'b1; updIndex = 4'd9; updTaken = 1'b0; updMispredict = 1'b1; updGhr = 4'h5;
    applyStimulus();
    updValid = 1'b0; updMispredict = 1'b0; lookupValid = 1'b0;
    #1;
    checkOutput("repair_ghr", 32'(ghrOut), 32'hA);
    checkOutput("repair_perf_mispred", 32'(perfMispred), 32'd1);
    checkOutput("repair_perf_lookups", 32'(perfLookups), 32'd5);

    // Same-cycle lookup and update of index 9: read-before-write.
    lookupValid = 1'b1; lookupPc = 32'h0C;
    updValid = 1'b1; updIndex = 4'd9; updTaken = 1'b1;
    #1;
    checkOutput("coll_index", 32'(predIndex), 32'd9);
    checkOutput("coll_old_valid", 32'(predValid), 32'd1);
    checkOutput("coll_old_taken", 32'(predTaken), 32'd0);
    applyStimulus();
    updValid = 1'b0; lookupPc = 32'h34;
    #1;
    checkOutput("coll_ghr", 32'(ghrOut), 32'h4);
    checkOutput("coll_new_index", 32'(predIndex), 32'd9);
    checkOutput("coll_new_taken", 32'(predTaken), 32'd1);
    lookupValid = 1'b0;

    // Reset overrides a concurrent update, repair and lookup.
    reset = 1'b1;
    updValid = 1'b1; updIndex = 4'd12; updTaken = 1'b1; updMispredict = 1'b1; updGhr = 4'h7;
    lookupValid = 1'b1; lookupPc = 32'h30;
    applyStimulus();
    reset = 1'b0; updValid = 1'b0; updMispredict = 1'b0; lookupValid = 1'b0;
    #1;
    checkOutput("midrst_ghr", 32'(ghrOut), 32'd0);
    checkOutput("midrst_perf_lookups", 32'(perfLookups), 32'd0);
    checkOutput("midrst_perf_mispred", 32'(perfMispred), 32'd0);
    lookupValid = 1'b1; lookupPc = 32'h30;
    #1;
    checkOutput("midrst_idx12_valid", 32'(predValid), 32'd0);
    lookupPc = 32'h24;
    #1;
    checkOutput("midrst_idx9_valid", 32'(predValid), 32'd0);
    lookupValid = 1'b0;

    // History-only indexing and perf counter saturation on the narrow instance.
    updValid0 = 1'b1; updIndex0 = 4'd3; updTaken0 = 1'b1; updMispredict0 = 1'b1; updGhr0 = 4'h1;
    applyStimulus();
    updValid0 = 1'b0; updMispredict0 = 1'b0;
    lookupValid0 = 1'b1; lookupPc0 = 32'h24;
    #1;
    checkOutput("hist_index", 32'(predIndex0), 32'h3);
    checkOutput("hist_pred_ghr", 32'(predGhr0), 32'h3);
    checkOutput("hist_valid", 32'(predValid0), 32'd1);
    checkOutput("hist_taken", 32'(predTaken0), 32'd1);
    checkOutput("hist_perf_mispred", 32'(perfMispred0), 32'd1);
    repeat (4) applyStimulus();
    lookupValid0 = 1'b0;
    #1;
    checkOutput("perf_lookups_sat", 32'(perfLookups0), 32'd3);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
